// File: rtl/acc_pkg.sv
// Shared types and defaults for the product accumulator and the multiplier wrapper.
// The beat struct uses the default widths so the wrapper can carry a result as one bus.
package acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    localparam int DATA_W_DEF = 32;
    localparam int ACC_LEN_DEF = 8;
    localparam int ACC_W_DEF = DATA_W_DEF + $clog2(ACC_LEN_DEF);
    localparam int CNT_W_DEF = $clog2(ACC_LEN_DEF + 1);

    typedef struct packed {
        logic [ACC_W_DEF-1:0] sum;
        logic [CNT_W_DEF-1:0] count;
    } acc_beat_t;

endpackage

// File: rtl/product_accumulator.sv
// Sums blocks of ACC_LEN unsigned products (or fewer on flush) and holds each
// block sum with its beat count on a valid/ready output until accepted.
//
// state | meaning
// ACCUM | accepting product beats into the partial sum
// HOLD  | block result presented on out_*, waiting for out_ready
module product_accumulator
    import acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_LEN = ACC_LEN_DEF,
    localparam int ACC_W = DATA_W + $clog2(ACC_LEN),
    localparam int CNT_W = $clog2(ACC_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    input  logic              out_ready
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

    acc_state_e       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] acc_next;

    // reset is folded in so in_ready drops the moment reset asserts
    assign in_ready = (state == ACCUM) && !clear && !reset;
    assign in_ext   = {{(ACC_W - DATA_W){1'b0}}, in_data};
    assign acc_next = acc + in_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (clear) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (flush || cnt == LAST_CNT) begin
                            out_data  <= acc_next;
                            out_count <= cnt + CNT_W'(1);
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= HOLD;
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (flush && cnt != '0) begin
                        out_data  <= acc;
                        out_count <= cnt;
                        out_valid <= 1'b1;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: a list-of-beats reference model
// predicts results and handshake levels; a negedge monitor checks presented results.
module tb_product_accumulator;
    import acc_pkg::*;

    localparam int DATA_W = 32;
    localparam int ACC_LEN = 8;
    localparam int ACC_W = 35;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_ready = 1'b0;

    product_accumulator #(.DATA_W(DATA_W), .ACC_LEN(ACC_LEN)) dut (
        .clk(clk), .reset(reset), .clear(clear), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sum;
        int     count;
    } res_t;

    int     n_checks = 0;
    int     n_pass = 0;
    res_t   exp_q[$];
    longint beats[$];
    bit     m_hold = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic longint beat_sum();
        longint s = 0;
        foreach (beats[i]) s += beats[i];
        return s;
    endfunction

    task automatic emit();
        res_t r;
        r.sum = beat_sum();
        r.count = beats.size();
        exp_q.push_back(r);
        beats.delete();
        m_hold = 1'b1;
    endtask

    // One clock: check last edge's outcome, drive inputs, predict the next edge.
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit fl,
                        input bit cl, input bit ordy);
        @(posedge clk);
        #2;
        chk("out_valid", longint'(out_valid), longint'(m_hold));
        in_valid = v;
        in_data = v ? d : 'x;
        flush = fl;
        clear = cl;
        out_ready = ordy;
        #1;
        chk("in_ready", longint'(in_ready), longint'(!m_hold && !cl));
        if (cl) begin
            beats.delete();
            if (m_hold) void'(exp_q.pop_back());
            m_hold = 1'b0;
        end else if (!m_hold) begin
            if (v) begin
                beats.push_back(longint'(d));
                if (fl || beats.size() == ACC_LEN) emit();
            end else if (fl && beats.size() > 0) begin
                emit();
            end
        end else if (ordy) begin
            m_hold = 1'b0;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset", longint'(in_ready), 1);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #4;
        reset = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        clear = 1'b0;
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_data", longint'(out_data), 0);
        beats.delete();
        if (m_hold) void'(exp_q.pop_back());
        m_hold = 1'b0;
        release_reset();
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && !clear) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got out_data=%0d out_count=%0d expected no result",
                         out_data, out_count);
            end else begin
                chk("out_data", longint'(out_data), exp_q[0].sum);
                chk("out_count", longint'(out_count), longint'(exp_q[0].count));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1;
        chk("reset_in_ready", longint'(in_ready), 0);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_data", longint'(out_data), 0);
        chk("reset_out_count", longint'(out_count), 0);
        release_reset();

        for (int i = 0; i < 8; i++) step(1, 32'd1000, 0, 0, 1);
        step(1, 32'd123, 0, 0, 1);
        chk("dir_sum_1000", longint'(out_data), 8000);
        chk("dir_cnt_1000", longint'(out_count), 8);

        for (int i = 0; i < 8; i++) step(1, 32'hFFFF_FFFF, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        chk("dir_sum_max", longint'(out_data), 64'h7_FFFF_FFF8);
        chk("dir_cnt_max", longint'(out_count), 8);

        for (int i = 0; i < 3; i++) step(1, 32'd5, 0, 0, 1);
        step(0, '0, 1, 0, 1);
        step(0, '0, 0, 0, 1);
        chk("dir_sum_flush", longint'(out_data), 15);
        chk("dir_cnt_flush", longint'(out_count), 3);
        step(0, '0, 1, 0, 1);
        step(0, '0, 1, 0, 1);
        step(0, '0, 0, 0, 1);

        for (int i = 0; i < 8; i++) step(1, 32'd7, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 32'd9, 0, 0, 0);
        chk("dir_sum_bp", longint'(out_data), 56);
        step(1, 32'd9, 0, 0, 1);

        for (int i = 0; i < 4; i++) step(1, 32'd11, 0, 0, 1);
        step(1, 32'd99, 0, 1, 1);
        for (int i = 0; i < 8; i++) step(1, 32'd2, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        chk("dir_sum_clear", longint'(out_data), 16);
        chk("dir_cnt_clear", longint'(out_count), 8);

        for (int i = 0; i < 8; i++) step(1, 32'd3, 0, 0, 1);
        step(0, '0, 0, 0, 0);
        step(1, 32'd50, 0, 1, 1);
        step(0, '0, 0, 0, 1);

        for (int i = 0; i < 5; i++) step(1, 32'd4, 0, 0, 1);
        async_reset();
        for (int i = 0; i < 8; i++) step(1, 32'd6, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        chk("dir_sum_post_reset", longint'(out_data), 48);

        for (int i = 0; i < 600; i++) begin
            logic [DATA_W-1:0] d;
            d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom());
            step($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 6);
            if (i == 300) async_reset();
        end

        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        #3;
        chk("scoreboard_drained", longint'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
